// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous input in system clock cycles.
// The input is resynchronised, edge-detected and timed by a single up-counter.
module period_meter #(
  parameter int               WIDTH      = 27,
  parameter logic [WIDTH-1:0] MAX_PERIOD = 27'h7FFFFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             measure_en,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] highTime_q, highTime_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             rise, fall;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      counter_q  <= '0;
      period_q   <= '0;
      highTime_q <= '0;
      shadow_q   <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      counter_q  <= counter_d;
      period_q   <= period_d;
      highTime_q <= highTime_d;
      shadow_q   <= shadow_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  // A rise that coincides with the timeout threshold still completes the period.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    period_d   = period_q;
    highTime_d = highTime_q;
    shadow_d   = shadow_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        counter_d = '0;
        if (measure_en) state_d = ARM;
      end
      ARM: begin
        if (!measure_en) begin
          state_d   = IDLE;
          counter_d = '0;
        end else if (rise) begin
          state_d   = MEASURE;
          counter_d = WIDTH'(1);
          shadow_d  = '0;
        end
      end
      MEASURE: begin
        if (!measure_en) begin
          state_d   = IDLE;
          counter_d = '0;
        end else if (rise) begin
          period_d   = counter_q;
          highTime_d = shadow_q;
          valid_d    = 1'b1;
          timeout_d  = 1'b0;
          counter_d  = WIDTH'(1);
          shadow_d   = '0;
        end else if (counter_q == MAX_PERIOD) begin
          timeout_d = 1'b1;
          counter_d = '0;
          state_d   = ARM;
        end else begin
          counter_d = counter_q + WIDTH'(1);
          if (fall) shadow_d = counter_q;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase
  end

  assign period       = period_q;
  assign high_time    = highTime_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: square waves, timeout, enable drop, reset and
// the rise-at-threshold corner, using a small MAX_PERIOD.
module tb_period_meter;

  localparam int WIDTH = 27;

  logic             clock = 1'b0;
  logic             reset;
  logic             sig_in;
  logic             measure_en;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             period_valid;
  logic             timeout;
  logic             busy;

  int   testCount = 0;
  int   failCount = 0;
  int   cyc, validCount, validWide, validGap, lastValidCyc, firstValidCyc;
  int   waveIdx, waveHi, waveLo;
  bit   waveOn;
  logic prevValid;

  period_meter #(.WIDTH(WIDTH), .MAX_PERIOD(27'd16)) dut (
    .clock        (clock),
    .reset        (reset),
    .sig_in       (sig_in),
    .measure_en   (measure_en),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Advances n clocks, tracks valid pulses and drives the square wave if enabled.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (period_valid === 1'b1) begin
        validCount++;
        if (firstValidCyc < 0) firstValidCyc = cyc;
        if (lastValidCyc >= 0) validGap = cyc - lastValidCyc;
        lastValidCyc = cyc;
        if (prevValid === 1'b1) validWide++;
      end
      prevValid = period_valid;
      waveIdx++;
      if (waveOn) sig_in = ((waveIdx % (waveHi + waveLo)) < waveHi);
    end
  endtask

  task automatic clearMonitor();
    cyc           = 0;
    validCount    = 0;
    validWide     = 0;
    validGap      = 0;
    lastValidCyc  = -1;
    firstValidCyc = -1;
    prevValid     = period_valid;
  endtask

  task automatic setWave(input int hi, input int lo);
    waveOn  = 1'b1;
    waveHi  = hi;
    waveLo  = lo;
    waveIdx = 0;
    sig_in  = 1'b1;
  endtask

  task automatic stopWave();
    waveOn = 1'b0;
    sig_in = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset      = 1'b1;
    measure_en = 1'b0;
    waveOn     = 1'b0;
    sig_in     = 1'b0;
    waveIdx    = 0;
    waveHi     = 1;
    waveLo     = 1;
    clearMonitor();
    applyStimulus(2);
    checkOutput("rst_period", period, 0);
    checkOutput("rst_high", high_time, 0);
    checkOutput("rst_valid", period_valid, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b0;
    applyStimulus(3);

    // Divider-style wave toggling every 2 clocks
    clearMonitor();
    measure_en = 1'b1;
    setWave(2, 2);
    applyStimulus(30);
    checkOutput("div_first_valid", firstValidCyc, 7);
    checkOutput("div_count", validCount, 6);
    checkOutput("div_period", period, 4);
    checkOutput("div_high", high_time, 2);
    checkOutput("div_gap", validGap, 4);
    checkOutput("div_wide", validWide, 0);

    // 3 high / 7 low
    measure_en = 1'b0;
    stopWave();
    applyStimulus(4);
    clearMonitor();
    measure_en = 1'b1;
    setWave(3, 7);
    applyStimulus(60);
    checkOutput("w10_first_valid", firstValidCyc, 13);
    checkOutput("w10_count", validCount, 5);
    checkOutput("w10_period", period, 10);
    checkOutput("w10_high", high_time, 3);
    checkOutput("w10_gap", validGap, 10);
    checkOutput("w10_wide", validWide, 0);

    // Drop enable mid-period
    measure_en = 1'b0;
    clearMonitor();
    applyStimulus(1);
    checkOutput("dis_busy", busy, 0);
    applyStimulus(20);
    checkOutput("dis_no_valid", validCount, 0);
    checkOutput("dis_period_hold", period, 10);
    stopWave();
    applyStimulus(4);
    clearMonitor();
    measure_en = 1'b1;
    setWave(3, 7);
    applyStimulus(30);
    checkOutput("reen_first_valid", firstValidCyc, 13);
    checkOutput("reen_period", period, 10);

    // Reset in the middle of a measurement
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("mrst_period", period, 0);
    checkOutput("mrst_high", high_time, 0);
    checkOutput("mrst_valid", period_valid, 0);
    checkOutput("mrst_timeout", timeout, 0);
    checkOutput("mrst_busy", busy, 0);
    reset = 1'b0;
    clearMonitor();
    applyStimulus(40);
    checkOutput("mrst_restart_count", (validCount >= 2), 1);
    checkOutput("mrst_restart_period", period, 10);
    checkOutput("mrst_restart_high", high_time, 3);

    // Single rise then hold low: timeout exactly 16 cycles after counting starts
    measure_en = 1'b0;
    stopWave();
    applyStimulus(4);
    clearMonitor();
    measure_en = 1'b1;
    sig_in     = 1'b1;
    applyStimulus(3);
    sig_in = 1'b0;
    applyStimulus(15);
    checkOutput("to_not_yet", timeout, 0);
    applyStimulus(1);
    checkOutput("to_set", timeout, 1);
    checkOutput("to_busy_arm", busy, 1);
    checkOutput("to_period_hold", period, 10);
    checkOutput("to_high_hold", high_time, 3);
    checkOutput("to_no_valid", validCount, 0);

    // Resume with a 6-cycle wave
    setWave(3, 3);
    applyStimulus(40);
    checkOutput("res_timeout_clear", timeout, 0);
    checkOutput("res_period", period, 6);
    checkOutput("res_high", high_time, 3);

    // Time out again, then a rise exactly at the threshold
    stopWave();
    applyStimulus(25);
    checkOutput("to2_set", timeout, 1);
    clearMonitor();
    setWave(8, 8);
    applyStimulus(50);
    checkOutput("max_first_valid", firstValidCyc, 19);
    checkOutput("max_count", validCount, 2);
    checkOutput("max_period", period, 16);
    checkOutput("max_high", high_time, 8);
    checkOutput("max_timeout", timeout, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period and high time of a slow periodic input, such as a divided clock or an external toggle. Results are in system clock cycles.
- It is the receiving counterpart of the team's frequency divider: the divider generates a slow square wave, and this block recovers its timing.
- It sits beside the processor clocking logic for self-check and debug readout.
- The input is asynchronous and is synchronized internally.

Parameters:
- WIDTH, 27, width of the cycle counter and of the period and high_time outputs.
- MAX_PERIOD, 27'h7FFFFFF, timeout threshold in cycles. Must satisfy 2 <= MAX_PERIOD <= 2^WIDTH-1.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  asynchronous signal to be measured.
- measure_en  input  1  level enable; measurement runs while high.
- period  output  WIDTH  cycles between consecutive rising edges; holds the last valid value.
- high_time  output  WIDTH  cycles from a rising edge to the following falling edge; holds the last valid value.
- period_valid  output  1  one-cycle pulse when period and high_time update.
- timeout  output  1  sticky flag: no rising edge seen within MAX_PERIOD cycles.
- busy  output  1  high in the ARM or MEASURE state.

Behaviour:
- Synchronizer and edge detection:
  - Two-flop synchronizer s1 -> s2, then a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An edge on sig_in reaches rise/fall 2-3 cycles later. This latency is identical for all edges, so measured intervals are unaffected.
- Reset: state=IDLE; s1, s2, s3, counter, period, high_time, period_valid, timeout and busy all 0.
- States:
  - IDLE: counter=0, busy=0. Go to ARM when measure_en=1.
  - ARM: busy=1. On rise, counter<=1 and go to MEASURE. Any fall in ARM is ignored.
  - MEASURE: busy=1; counter<=counter+1 each cycle.
    - On fall: high_time_shadow<=counter.
    - On rise: period<=counter, high_time<=high_time_shadow, period_valid<=1 for exactly one cycle, timeout<=0, counter<=1, stay in MEASURE.
- Counting rule:
  - A rise in cycle t followed by the next rise in cycle t+P gives period=P.
  - A fall in cycle t+H gives high_time=H.
- Output timing: period, high_time and period_valid are registered. They change in the cycle after the rise that completes a period.
- Timeout: in MEASURE, if counter==MAX_PERIOD and there is no rise this cycle:
  - timeout<=1, counter<=0, state goes to ARM.
  - No period_valid; period and high_time hold.
  - The counter never wraps.
- measure_en low in any state:
  - Next state IDLE, counter<=0.
  - A partial measurement is discarded: no period_valid.
  - period, high_time and timeout hold.
- Simultaneous events:
  - measure_en=0 together with a rise: IDLE wins, no valid.
  - counter==MAX_PERIOD together with a rise: the rise wins, period=MAX_PERIOD, valid, no timeout.
- High time is taken only from a fall inside the current period. If no fall occurred, high_time reports 0; this cannot happen after synchronization and is not a normal case.
- reset asserted mid-measurement: all state returns to reset values on the next clock edge.

Test Plan:
- Drive sig_in from the team divider with FREQ=1 (toggles every 2 clocks); measure_en=1.
  - After the first full period: period=4, high_time=2.
  - Then one period_valid pulse every 4 cycles, values constant.
- Set sig_in high 3 cycles and low 7 cycles, repeating.
  - period=10, high_time=3.
  - period_valid is exactly 1 cycle wide, 10 cycles apart.
- With MAX_PERIOD=16, hold sig_in low after one rise.
  - timeout=1 exactly 16 cycles after the counter starts; state returns to ARM; period is unchanged.
  - Resume a 6-cycle square wave: timeout clears and period=6.
- Deassert measure_en mid-period.
  - busy=0 next cycle; no period_valid; period holds.
  - Re-enable: the first valid appears only after two rises.
- Assert reset mid-MEASURE while period=10.
  - All outputs read 0 next cycle.
  - Measurement restarts correctly after reset is released.
- Apply a rise in the same cycle as counter==MAX_PERIOD.
  - period=MAX_PERIOD, period_valid=1, timeout stays 0.
